// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-granular round-robin arbiter sharing the write port of the
// two-clock FIFO between CH_N requester streams in the wclk domain.
// Each granted packet is written as one header word (channel id), followed by the
// payload until last. A grant is only issued when the FIFO can hold a
// maximum-length packet plus header. Packets longer than PKT_MAX are cut and flagged.
//
// Ports:
//   wclk, wrst        write clock, synchronous active-high reset
//   ch_valid_i        per-channel word valid
//   ch_data_i         per-channel word, channel i at [i*DATA_W +: DATA_W]
//   ch_last_i         per-channel last word of packet
//   ch_ready_o        per-channel word accepted (valid & ready = beat)
//   fifo_wdata_o      FIFO write data
//   fifo_wen_o        FIFO write enable
//   fifo_wfull_i      FIFO full
//   fifo_wload_i      FIFO fill level (write domain)
//   busy_o            high while a packet is in progress
//   grant_id_o        current or last granted channel
//   err_trunc_o       sticky per-channel truncation flags
//   err_clr_i         clears all truncation flags
module fifo_wr_arbiter #(
    parameter int unsigned CH_N        = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WORDS_TOTAL = 2 ** ADDR_W,
    parameter int unsigned PKT_MAX     = 64
) (
    input  logic                       wclk,
    input  logic                       wrst,
    input  logic [CH_N-1:0]            ch_valid_i,
    input  logic [CH_N*DATA_W-1:0]     ch_data_i,
    input  logic [CH_N-1:0]            ch_last_i,
    output logic [CH_N-1:0]            ch_ready_o,
    output logic [DATA_W-1:0]          fifo_wdata_o,
    output logic                       fifo_wen_o,
    input  logic                       fifo_wfull_i,
    input  logic [ADDR_W:0]            fifo_wload_i,
    output logic                       busy_o,
    output logic [$clog2(CH_N)-1:0]    grant_id_o,
    output logic [CH_N-1:0]            err_trunc_o,
    input  logic                       err_clr_i
);

    localparam int unsigned ID_W   = $clog2(CH_N);
    localparam int unsigned CNT_W  = $clog2(PKT_MAX + 1);
    localparam int unsigned LOAD_W = ADDR_W + 2;

    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   rr_last_q, rr_last_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CH_N-1:0]   err_trunc_q, err_trunc_d;

    logic [LOAD_W-1:0] load_need;
    logic              space_ok;
    logic              arb_found;
    logic [ID_W-1:0]   arb_id;
    logic [ID_W-1:0]   arb_cand;
    logic              beat;

    // Phrased as load + need <= total so the unsigned math cannot underflow.
    assign load_need = LOAD_W'(fifo_wload_i) + LOAD_W'(PKT_MAX + 1);
    assign space_ok  = (load_need <= LOAD_W'(WORDS_TOTAL));

    // First valid channel searching upward from rr_last+1, wrapping modulo CH_N.
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        arb_cand  = '0;
        for (int i = 1; i <= int'(CH_N); i++) begin
            arb_cand = ID_W'((int'(rr_last_q) + i) % int'(CH_N));
            if (!arb_found && ch_valid_i[arb_cand]) begin
                arb_found = 1'b1;
                arb_id    = arb_cand;
            end
        end
    end

    assign beat = (state_q == StData) && ch_valid_i[grant_id_q] && !fifo_wfull_i;

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        rr_last_d    = rr_last_q;
        beat_cnt_d   = beat_cnt_q;
        err_trunc_d  = err_clr_i ? '0 : err_trunc_q;
        ch_ready_o   = '0;
        fifo_wen_o   = 1'b0;
        fifo_wdata_o = '0;
        unique case (state_q)
            StIdle: begin
                if (space_ok && arb_found) begin
                    grant_id_d = arb_id;
                    state_d    = StHdr;
                end
            end
            StHdr: begin
                fifo_wen_o   = !fifo_wfull_i;
                fifo_wdata_o = DATA_W'(grant_id_q);
                if (!fifo_wfull_i) begin
                    state_d    = StData;
                    beat_cnt_d = '0;
                end
            end
            StData: begin
                ch_ready_o[grant_id_q] = !fifo_wfull_i;
                fifo_wen_o             = beat;
                fifo_wdata_o           = ch_data_i[int'(grant_id_q) * int'(DATA_W) +: DATA_W];
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (ch_last_i[grant_id_q]) begin
                        state_d   = StIdle;
                        rr_last_d = grant_id_q;
                    end else if (beat_cnt_q == CNT_W'(PKT_MAX - 1)) begin
                        // Remaining words of this channel go out as a fresh packet later.
                        err_trunc_d[grant_id_q] = 1'b1;
                        state_d                 = StIdle;
                        rr_last_d               = grant_id_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q     <= StIdle;
            grant_id_q  <= '0;
            rr_last_q   <= ID_W'(CH_N - 1);
            beat_cnt_q  <= '0;
            err_trunc_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_last_q   <= rr_last_d;
            beat_cnt_q  <= beat_cnt_d;
            err_trunc_q <= err_trunc_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign grant_id_o  = grant_id_q;
    assign err_trunc_o = err_trunc_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Packet-granular round-robin arbiter that shares the write port of the two-clock FIFO (`fifo_async`) between `CH_N` requester streams in the `wclk` domain. For each granted packet it writes one header word (channel id), then streams payload until `last`. It grants a packet only when the FIFO has room for a maximum-length packet, so a packet never stalls mid-stream on a full FIFO under normal operation. Packets longer than `PKT_MAX` are truncated and flagged.

## Interface
- `CH_N`, 4: number of requester channels, 2..16.
- `DATA_W`, 8: word width; must be >= $clog2(CH_N).
- `ADDR_W`, 10: FIFO address width; matches the FIFO instance.
- `WORDS_TOTAL`, 2**ADDR_W: FIFO capacity; matches the FIFO instance.
- `PKT_MAX`, 64: maximum payload words per packet; `PKT_MAX+1` <= `WORDS_TOTAL`.
- `ID_W` (localparam): $clog2(CH_N).

Ports:
- `wclk` in 1: write-domain clock.
- `wrst` in 1: synchronous, active-high reset, on `wclk`.
- `ch_valid` in CH_N: per-channel word valid.
- `ch_data` in CH_N*DATA_W: per-channel word; channel i occupies bits [i*DATA_W +: DATA_W].
- `ch_last` in CH_N: per-channel last word of packet.
- `ch_ready` out CH_N: per-channel word accepted (valid & ready = beat).
- `fifo_wdata` out DATA_W: to FIFO `wdata`.
- `fifo_wen` out 1: to FIFO `wen`.
- `fifo_wfull` in 1: from FIFO `wfull`.
- `fifo_wload` in ADDR_W+1: from FIFO `wload`.
- `busy` out 1: high in HDR/DATA.
- `grant_id` out ID_W: current or last granted channel.
- `err_trunc` out CH_N: sticky truncation flag per channel.
- `err_clr` in 1: clears all `err_trunc` bits.

## Operation
- FSM states: IDLE, HDR, DATA. Reset state is IDLE.
- IDLE, space check: `space_ok = (WORDS_TOTAL - fifo_wload) >= PKT_MAX+1`. Compute in ADDR_W+2 bits, unsigned, no underflow.
- IDLE, arbitration: if `space_ok` and any `ch_valid`, pick the first valid channel searching from `rr_last+1` modulo CH_N upward. Register it in `grant_id` and go to HDR.
- HDR: `fifo_wen = !fifo_wfull`; `fifo_wdata = grant_id` zero-extended.
  - If `!fifo_wfull`, go to DATA and clear `beat_cnt` to 0.
  - Otherwise hold in HDR.
- DATA, signals for granted channel g only:
  - `ch_ready[g] = !fifo_wfull`.
  - `fifo_wen = ch_valid[g] && !fifo_wfull`.
  - `fifo_wdata = ch_data[g]`.
  - All other `ch_ready` bits are 0.
- DATA, on each beat: `beat_cnt` increments (width $clog2(PKT_MAX+1)).
  - If `ch_last[g]`, go to IDLE.
  - Else if `beat_cnt == PKT_MAX-1`, set `err_trunc[g]` and go to IDLE. The channel's remaining words form a new packet on a later grant.
- On leaving DATA, `rr_last <= grant_id`.
- `ch_valid` deasserting mid-packet: stall in DATA indefinitely. There is no timeout.
- `err_clr` and a truncation in the same cycle: the set wins for that bit; all other bits clear.
- Outputs outside HDR/DATA: `fifo_wen=0`, `ch_ready=0`. `fifo_wdata` is don't-care when `fifo_wen=0`; drive it to 0.

## Timing
- Reset values: IDLE, `busy=0`, `grant_id=0`, `rr_last=CH_N-1` (channel 0 wins first), `err_trunc=0`, `beat_cnt=0`, `fifo_wen=0`, `ch_ready=0`.
- `wrst` mid-packet: abort immediately to IDLE. A partial packet may remain in the FIFO; the FIFO is reset by the same `wrst`.
- Grant latency: channel valid in IDLE cycle t gives `busy=1` and HDR in cycle t+1 and the header write in t+1 (FIFO not full). The first payload beat can occur in t+2.
- Packet of N payload words, no stalls, costs N+2 cycles including the IDLE decision cycle. Back-to-back packets therefore have exactly one idle cycle between them.
- The mandatory IDLE cycle lets the registered `fifo_wload` reflect the previous packet's last write before the next `space_ok` check.
- `fifo_wload` lagging read-pointer progress only makes `space_ok` conservative. This is allowed.
- `ch_ready` and `fifo_wen` are combinational from `state`, `grant_id`, `ch_valid` and `fifo_wfull`. There is no combinational path from `fifo_wload` to any output.

## Test plan
- After reset, ch0..ch3 each offer a 3-word packet simultaneously -> FIFO receives 0,a,b,c, 1,.., 2,.., 3,.. in that order; one idle cycle between packets; `err_trunc=0`.
- ch2 offers 2 packets back-to-back, ch1 offers 1, `rr_last=2` -> order ch1, ch2, ch2. Round-robin skips the just-served channel while another is valid.
- `PKT_MAX=4`, ch0 sends 6 words with `last` on the 6th -> packets [0,w0..w3] and [0,w4,w5]; `err_trunc[0]=1` until `err_clr` pulses, then 0.
- `fifo_wload = WORDS_TOTAL-PKT_MAX` with ch0 valid -> no grant, `busy=0`. Lower `wload` by 1 -> grant on the next cycle.
- `fifo_wfull` forced high for 3 cycles during DATA -> `ch_ready=0` and `fifo_wen=0` for those cycles; no word lost or duplicated.
- `wrst` asserted in DATA mid-packet -> next cycle IDLE, all outputs at reset values, ch0 granted first afterward.
